key_click_gen: RTL and testbench
================================

Name: key_click_gen

Overview:
- Encoder counterpart of the key click classifier. It takes a one-hot click command (single / long / double) and synthesises an active-low key waveform on KEY_Out.
- The waveform has press, gap and quiet timing chosen so the classifier decodes exactly that command.
- Used as an on-board self-test stimulus source (KEY_Out looped into the classifier's KEY input) and for driving a key line on a second board.

Parameters:
- T_SHORT, 5_000_000: low time of a single-click press and of each double-click press, in CLOCK cycles (100 ms at 50 MHz).
- T_LONG, 75_000_000: low time of a long-click press (1.5 s).
- T_GAP, 5_000_000: high time between the two presses of a double click.
- T_QUIET, 25_000_000: guaranteed high time after the last release, before Done_Sig.
- BOUNCE_N, 4: bounce slots per edge (used only with the optional feature).
- BOUNCE_T, 50_000: cycles per bounce slot (used only with the optional feature).
- Legality: all T_* ≥ 2. With the feature enabled, BOUNCE_N*BOUNCE_T < min(T_SHORT, T_GAP, T_QUIET).

Ports:
- CLOCK  input  1: system clock.
- RST_n  input  1: asynchronous, active-low reset.
- Cmd_Sig  input  3: one-hot command. Bit0 single, bit1 long, bit2 double (same bit order as the classifier's Pin_Out).
- KEY_Out  output  1: synthesised key level. 1 = released, 0 = pressed.
- Busy_Sig  output  1: high while a pattern is in progress.
- Done_Sig  output  1: one-cycle pulse when a pattern completes.

Behaviour:
- Single clock domain. Reset is asynchronous on the falling edge of RST_n and takes effect immediately.
- Reset values: KEY_Out=1, Busy_Sig=0, Done_Sig=0, state=IDLE, counter=0, command latch=0.
- All outputs are registered.
- States: IDLE, PRESS1, GAP, PRESS2, QUIET.
- IDLE:
  - KEY_Out=1, Busy_Sig=0.
  - A command is accepted only if Cmd_Sig has exactly one bit set (001, 010, 100). Values 000, 011, 101, 110 and 111 are ignored.
  - On acceptance, at the same edge: latch the command, go to PRESS1, KEY_Out←0, Busy_Sig←1, load the counter with the press length.
  - Latency: KEY_Out falls 1 cycle after the sampling edge.
- PRESS1:
  - KEY_Out held low for exactly T_SHORT cycles (single, double) or T_LONG cycles (long).
  - Then go to GAP if the command is double, otherwise to QUIET.
- GAP: KEY_Out high for exactly T_GAP cycles, then go to PRESS2.
- PRESS2: KEY_Out low for exactly T_SHORT cycles, then go to QUIET.
- QUIET: KEY_Out high for exactly T_QUIET cycles. At the final count, go to IDLE with Busy_Sig←0 and Done_Sig←1 for one cycle.
- Done cycle: the first IDLE cycle carries Done_Sig=1. A valid command sampled in that cycle is accepted normally, which allows back-to-back patterns.
- Cmd_Sig is ignored while Busy_Sig=1. Commands are never queued.
- Counter: a single down-counter, width $clog2(max(T_*)+1), loaded with T−1 on each phase entry. The phase ends when the counter is 0. No wrap: it only reloads on a state change.
- Reset mid-pattern: KEY_Out returns to 1 immediately (asynchronously). No Done_Sig is produced and the pattern is abandoned.
- Total Busy_Sig durations:
  - single: T_SHORT+T_QUIET
  - long: T_LONG+T_QUIET
  - double: 2*T_SHORT+T_GAP+T_QUIET

Optional Feature:
- Macro: KEY_CLICK_GEN_BOUNCE_EN.
- Defined:
  - The first BOUNCE_N*BOUNCE_T cycles of PRESS1, GAP, PRESS2 and QUIET are split into BOUNCE_N slots of BOUNCE_T cycles each.
  - Even slots drive the nominal phase level; odd slots drive its inverse.
  - The remainder of the phase is clean. Phase lengths are unchanged.
  - Purpose: exercises the classifier's debounce logic.
- Undefined: KEY_Out is clean, with exactly one transition per phase boundary. The bounce logic and the BOUNCE_* parameters are unused.

Decomposition:
- Shared package/include holds:
  - command encodings CMD_SINGLE=3'b001, CMD_LONG=3'b010, CMD_DOUBLE=3'b100, shared with the classifier;
  - state encodings for IDLE, PRESS1, GAP, PRESS2, QUIET.
- One sub-module: click_phase_timer.
  - Loadable down-counter with a terminal-count flag.
  - Also provides the bounce-slot index when the feature is enabled.

Test Plan (sim parameters: T_SHORT=10, T_LONG=40, T_GAP=8, T_QUIET=20, BOUNCE_N=2, BOUNCE_T=2):
- Single: Cmd_Sig=001 for 1 cycle in IDLE → KEY_Out low 10 cycles, then high; Busy_Sig high 30 cycles; Done_Sig pulse at cycle 31.
- Long: Cmd_Sig=010 → KEY_Out low 40 cycles; Busy_Sig 60 cycles; one Done_Sig pulse.
- Double: Cmd_Sig=100 → KEY_Out low 10, high 8, low 10, high 20; Busy_Sig 48 cycles; then Done_Sig.
- Illegal/busy commands:
  - Cmd_Sig=011 or 000 in IDLE → no activity.
  - Cmd_Sig=010 during a single pattern → ignored; the single completes unchanged.
  - Cmd_Sig=001 in the Done cycle → new pattern starts the next cycle.
- Reset: RST_n low at cycle 5 of PRESS1 → KEY_Out=1 and Busy_Sig=0 asynchronously; no Done_Sig; after release, a new command runs normally.
- Bounce enabled: single → KEY_Out pattern 0,0,1,1, then 0 for 6 cycles, then 1,1,0,0, then 1 for 16 cycles; closed loop with the classifier shows a single-click pulse.

Source files
------------

// File: rtl/key_click_gen_pkg.sv
// key_click_gen_pkg: command/state encodings shared with the click classifier, plus helpers.
package key_click_gen_pkg;
  localparam logic [2:0] CMD_SINGLE = 3'b001;
  localparam logic [2:0] CMD_LONG   = 3'b010;
  localparam logic [2:0] CMD_DOUBLE = 3'b100;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_PRESS1 = 3'd1;
  localparam state_t ST_GAP    = 3'd2;
  localparam state_t ST_PRESS2 = 3'd3;
  localparam state_t ST_QUIET  = 3'd4;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction
  function automatic logic is_cmd(input logic [2:0] c);
    return c == CMD_SINGLE || c == CMD_LONG || c == CMD_DOUBLE;
  endfunction
endpackage

// File: rtl/key_click_gen_if.sv
// key_click_gen_if: command in, synthesised key level and status out.
interface key_click_gen_if;
  logic [2:0] Cmd_Sig;
  logic       KEY_Out;
  logic       Busy_Sig;
  logic       Done_Sig;
  modport master (output Cmd_Sig, input KEY_Out, Busy_Sig, Done_Sig);
  modport slave  (input Cmd_Sig, output KEY_Out, Busy_Sig, Done_Sig);
endinterface

// File: rtl/key_click_gen_click_phase_timer.sv
// click_phase_timer: loadable phase down-counter with terminal flag; with KEY_CLICK_GEN_BOUNCE_EN
// it also tracks bounce slots and flags when the next cycle falls in an odd (inverted) slot.
module click_phase_timer #(
  parameter int CW       = 8,
  parameter int BOUNCE_N = 4,
  parameter int BOUNCE_T = 50_000
) (
  input  logic          CLOCK,
  input  logic          RST_n,
  input  logic          load_i,
  input  logic [CW-1:0] val_i,
  output logic          tc_o,
  output logic          bounce_o
);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign tc_o = cnt_q == '0;
`ifdef KEY_CLICK_GEN_BOUNCE_EN
  localparam int SW = $clog2(BOUNCE_N + 1);
  localparam int BW = $clog2(BOUNCE_T + 1);
  logic [SW-1:0] slot_q, slot_d;
  logic [BW-1:0] sub_q, sub_d;
  logic          wrap;
  assign wrap = sub_q == BW'(BOUNCE_T - 1);
  // slot index saturates at BOUNCE_N, which marks the clean remainder of the phase
  always_comb begin
    slot_d = slot_q;
    sub_d  = sub_q;
    if (load_i) begin
      slot_d = '0;
      sub_d  = '0;
    end else if (slot_q != SW'(BOUNCE_N)) begin
      sub_d  = wrap ? '0 : sub_q + 1'b1;
      slot_d = wrap ? slot_q + 1'b1 : slot_q;
    end
  end
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      slot_q <= SW'(BOUNCE_N);
      sub_q  <= '0;
    end else begin
      slot_q <= slot_d;
      sub_q  <= sub_d;
    end
  end
  assign bounce_o = slot_d != SW'(BOUNCE_N) && slot_d[0];
`else
  assign bounce_o = 1'b0;
`endif
endmodule

// File: rtl/key_click_gen.sv
// key_click_gen: synthesises an active-low key waveform for a one-hot click command.
// Optional contact bounce on every edge when KEY_CLICK_GEN_BOUNCE_EN is defined.
module key_click_gen
  import key_click_gen_pkg::*;
#(
  parameter int T_SHORT  = 5_000_000,
  parameter int T_LONG   = 75_000_000,
  parameter int T_GAP    = 5_000_000,
  parameter int T_QUIET  = 25_000_000,
  parameter int BOUNCE_N = 4,
  parameter int BOUNCE_T = 50_000
) (
  input logic           CLOCK,
  input logic           RST_n,
  key_click_gen_if.slave bus
);
  localparam int CW = $clog2(max4(T_SHORT, T_LONG, T_GAP, T_QUIET) + 1);
  state_t        state_q, state_d;
  logic [2:0]    cmd_q, cmd_d;
  logic          key_q, key_d, busy_q, done_q, done_d;
  logic          load, tc, bounce;
  logic [CW-1:0] lval;
  click_phase_timer #(.CW(CW), .BOUNCE_N(BOUNCE_N), .BOUNCE_T(BOUNCE_T)) u_timer (
    .CLOCK(CLOCK), .RST_n(RST_n), .load_i(load), .val_i(lval), .tc_o(tc), .bounce_o(bounce)
  );
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    load    = 1'b0;
    lval    = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (is_cmd(bus.Cmd_Sig)) begin
        cmd_d   = bus.Cmd_Sig;
        state_d = ST_PRESS1;
        load    = 1'b1;
        lval    = bus.Cmd_Sig == CMD_LONG ? CW'(T_LONG - 1) : CW'(T_SHORT - 1);
      end
      ST_PRESS1: if (tc) begin
        state_d = cmd_q == CMD_DOUBLE ? ST_GAP : ST_QUIET;
        load    = 1'b1;
        lval    = cmd_q == CMD_DOUBLE ? CW'(T_GAP - 1) : CW'(T_QUIET - 1);
      end
      ST_GAP: if (tc) begin
        state_d = ST_PRESS2;
        load    = 1'b1;
        lval    = CW'(T_SHORT - 1);
      end
      ST_PRESS2: if (tc) begin
        state_d = ST_QUIET;
        load    = 1'b1;
        lval    = CW'(T_QUIET - 1);
      end
      ST_QUIET: if (tc) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // key level is the phase's nominal level, inverted during odd bounce slots
  assign key_d = state_d == ST_IDLE ? 1'b1
               : (state_d != ST_PRESS1 && state_d != ST_PRESS2) ^ bounce;
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      key_q   <= key_d;
      busy_q  <= state_d != ST_IDLE;
      done_q  <= done_d;
    end
  end
  assign bus.KEY_Out  = key_q;
  assign bus.Busy_Sig = busy_q;
  assign bus.Done_Sig = done_q;
endmodule

// File: tb/tb_key_click_gen.sv
// tb_key_click_gen: directed cycle-by-cycle check of the key waveform, busy and done pulse.
module tb_key_click_gen;
  localparam int TS = 10, TL = 40, TG = 8, TQ = 20, BN = 2, BT = 2;
  logic CLOCK = 1'b0, RST_n = 1'b0;
  int   n_pass = 0, n_chk = 0;
  key_click_gen_if bus();
  key_click_gen #(.T_SHORT(TS), .T_LONG(TL), .T_GAP(TG), .T_QUIET(TQ), .BOUNCE_N(BN), .BOUNCE_T(BT)) dut (
    .CLOCK(CLOCK), .RST_n(RST_n), .bus(bus)
  );
  always #5 CLOCK = ~CLOCK;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic int total(input logic [2:0] c);
    return c == 3'b100 ? 2 * TS + TG + TQ : (c == 3'b010 ? TL : TS) + TQ;
  endfunction
  function automatic logic exp_key(input logic [2:0] c, input int k);
    int d[4];
    logic l;
    int o;
    d = c == 3'b100 ? '{TS, TG, TS, TQ} : '{(c == 3'b010 ? TL : TS), TQ, 0, 0};
    o = k;
    for (int i = 0; i < 4; i++) begin
      if (o < d[i]) begin
        l = (c == 3'b100) ? i[0] : (i != 0);
`ifdef KEY_CLICK_GEN_BOUNCE_EN
        if (o < BN * BT && ((o / BT) % 2) == 1) l = ~l;
`endif
        return l;
      end
      o -= d[i];
    end
    return 1'b1;
  endfunction
  task automatic idle(input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      bus.Cmd_Sig = c;
      @(negedge CLOCK);
      check($sformatf("idle%0b key", c), int'(bus.KEY_Out), 1);
      check($sformatf("idle%0b busy", c), int'(bus.Busy_Sig), 0);
      check($sformatf("idle%0b done", c), int'(bus.Done_Sig), 0);
    end
  endtask
  task automatic play(input logic [2:0] c, input int ik, input logic [2:0] ic);
    int t;
    t = total(c);
    bus.Cmd_Sig = c;
    @(negedge CLOCK);
    for (int k = 0; k <= t; k++) begin
      bus.Cmd_Sig = (k == ik) ? ic : 3'b000;
      check($sformatf("c%0b k%0d key", c, k), int'(bus.KEY_Out), int'(exp_key(c, k)));
      check($sformatf("c%0b k%0d busy", c, k), int'(bus.Busy_Sig), int'(k < t));
      check($sformatf("c%0b k%0d done", c, k), int'(bus.Done_Sig), int'(k == t));
      if (k < t) @(negedge CLOCK);
    end
  endtask
  initial begin
    bus.Cmd_Sig = 3'b000;
    #12;
    check("rst key", int'(bus.KEY_Out), 1);
    check("rst busy", int'(bus.Busy_Sig), 0);
    check("rst done", int'(bus.Done_Sig), 0);
    @(negedge CLOCK);
    RST_n = 1'b1;
    idle(3'b000, 3);
    play(3'b001, -1, 3'b000);
    idle(3'b011, 4);
    play(3'b010, -1, 3'b000);
    idle(3'b111, 2);
    play(3'b100, -1, 3'b000);
    idle(3'b000, 2);
    play(3'b001, 3, 3'b010);
    idle(3'b110, 2);
    play(3'b001, total(3'b001), 3'b001);
    play(3'b001, -1, 3'b000);
    idle(3'b101, 2);
    bus.Cmd_Sig = 3'b001;
    @(negedge CLOCK);
    bus.Cmd_Sig = 3'b000;
    repeat (4) @(negedge CLOCK);
    check("pre-rst key low", int'(bus.KEY_Out), int'(exp_key(3'b001, 4)));
    #2 RST_n = 1'b0;
    #1;
    check("async rst key", int'(bus.KEY_Out), 1);
    check("async rst busy", int'(bus.Busy_Sig), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      check("in rst done", int'(bus.Done_Sig), 0);
      check("in rst key", int'(bus.KEY_Out), 1);
    end
    RST_n = 1'b1;
    idle(3'b000, 40);
    play(3'b001, -1, 3'b000);
    idle(3'b000, 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
